// File: rtl/serdes_test_data_gen.sv
// Transmit-side SerDes link test pattern generator: fixed-length frames of two
// header words plus counter-stamped payload, with single-shot error injection.
module serdes_test_data_gen #(
   parameter logic        C_CHANNEL_FOR_CPRI_TDM = 1'b0,
   parameter logic [15:0] SYMBOL_CNT_TBL   [0:9] = '{16'd1023, 16'd2047, 16'd2559, 16'd4095,
                                                     16'd5119, 16'd8191, 16'd8191, 16'd10239,
                                                     16'd12287, 16'd24575},
   parameter logic [15:0] TDM_CHIP_CNT_TBL [0:9] = '{16'd3, 16'd7, 16'd9, 16'd15, 16'd19,
                                                     16'd31, 16'd31, 16'd39, 16'd47, 16'd95}
) (
   input  logic        I_txoutclk,
   input  logic        I_txoutrst,
   input  logic        I_gen_en,
   input  logic [3:0]  I_serdes_rate_sel,
   input  logic        I_8b10b_or_64b66b_sel,
   input  logic        I_err_inject,
   output logic [7:0]  O_txctrl,
   output logic [63:0] O_txdata,
   output logic        O_frame_start,
   output logic [15:0] O_frame_cnt,
   output logic        O_inject_done
);

   localparam int unsigned K_W    = 16;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned CTRL_W = 8;
   localparam int unsigned RATE_W = 4;
   localparam int unsigned N_RATE = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [K_W-1:0]      k_q, k_d;
   logic [RATE_W-1:0]   rate_q, rate_d;
   logic                coding_q, coding_d;
   logic                err_in_q, err_in_d;
   logic                pending_q, pending_d;
   logic [CTRL_W-1:0]   txctrl_q, txctrl_d;
   logic [DATA_W-1:0]   txdata_q, txdata_d;
   logic                frame_start_q, frame_start_d;
   logic [K_W-1:0]      frame_cnt_q, frame_cnt_d;
   logic                inject_done_q, inject_done_d;

   logic [K_W-1:0]      term_c;
   logic                active_c;

   // Terminal word index for the latched rate; unsupported rates never wrap early
   always_comb begin
      term_c = 16'hFFFF;
      for (int i = 0; i < int'(N_RATE); i++) begin
         if (rate_q == RATE_W'(i)) begin
            term_c = C_CHANNEL_FOR_CPRI_TDM ? TDM_CHIP_CNT_TBL[i] : SYMBOL_CNT_TBL[i];
         end
      end
   end

   // Next state, counter, shadow selects and registered word contents
   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      rate_d        = rate_q;
      coding_d      = coding_q;
      err_in_d      = I_err_inject;
      pending_d     = pending_q | (I_err_inject & ~err_in_q);
      txctrl_d      = '0;
      txdata_d      = '0;
      frame_start_d = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      inject_done_d = 1'b0;
      active_c      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (I_gen_en) begin
               state_d  = ST_RUN;
               k_d      = '0;
               rate_d   = I_serdes_rate_sel;
               coding_d = I_8b10b_or_64b66b_sel;
            end
         end
         ST_RUN: begin
            active_c = 1'b1;
            if (k_q == term_c) begin
               k_d      = '0;
               rate_d   = I_serdes_rate_sel;
               coding_d = I_8b10b_or_64b66b_sel;
               if (!I_gen_en) state_d = ST_IDLE;
            end else begin
               k_d = k_q + K_W'(1);
               if (!I_gen_en) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            active_c = 1'b1;
            if (k_q == term_c) begin
               k_d      = '0;
               rate_d   = I_serdes_rate_sel;
               coding_d = I_8b10b_or_64b66b_sel;
               state_d  = ST_IDLE;
            end else begin
               k_d = k_q + K_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            k_d     = '0;
         end
      endcase

      if (active_c) begin
         if (k_q == K_W'(0)) begin
            txctrl_d      = coding_q ? 8'h80 : 8'h01;
            txdata_d      = coding_q ? 64'hFD50505050505050 : 64'h50505050505050BC;
            frame_start_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + K_W'(1);
         end else if (k_q == K_W'(1)) begin
            txctrl_d = coding_q ? 8'h01 : 8'h00;
            txdata_d = coding_q ? 64'h50505050505050FB : 64'h5050505050505050;
         end else begin
            txctrl_d = 8'h00;
            txdata_d = {k_q, 16'h0000, k_q, k_q};
            // Payload only: headers must stay intact for the checker to lock
            if (pending_q) begin
               txdata_d[0]   = ~txdata_d[0];
               inject_done_d = 1'b1;
               pending_d     = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge I_txoutclk) begin
      if (I_txoutrst) begin
         state_q       <= ST_IDLE;
         k_q           <= '0;
         rate_q        <= '0;
         coding_q      <= 1'b0;
         err_in_q      <= 1'b0;
         pending_q     <= 1'b0;
         txctrl_q      <= '0;
         txdata_q      <= '0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
         inject_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         rate_q        <= rate_d;
         coding_q      <= coding_d;
         err_in_q      <= err_in_d;
         pending_q     <= pending_d;
         txctrl_q      <= txctrl_d;
         txdata_q      <= txdata_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
         inject_done_q <= inject_done_d;
      end
   end

   assign O_txctrl      = txctrl_q;
   assign O_txdata      = txdata_q;
   assign O_frame_start = frame_start_q;
   assign O_frame_cnt   = frame_cnt_q;
   assign O_inject_done = inject_done_q;

endmodule

// File: tb/tb_serdes_test_data_gen.sv
// Directed bench for serdes_test_data_gen: CPRI instance plus a TDM instance
// sharing the same stimulus.
module tb_serdes_test_data_gen;

   logic        clk;
   logic        rst;
   logic        gen_en;
   logic [3:0]  rate_sel;
   logic        coding_sel;
   logic        err_inject;

   logic [7:0]  m_ctrl, t_ctrl;
   logic [63:0] m_data, t_data;
   logic        m_fs, t_fs;
   logic [15:0] m_cnt, t_cnt;
   logic        m_idone, t_idone;

   int checks = 0;
   int errors = 0;
   int n;
   logic [63:0] prev;

   serdes_test_data_gen u_cpri (
      .I_txoutclk            (clk),
      .I_txoutrst            (rst),
      .I_gen_en              (gen_en),
      .I_serdes_rate_sel     (rate_sel),
      .I_8b10b_or_64b66b_sel (coding_sel),
      .I_err_inject          (err_inject),
      .O_txctrl              (m_ctrl),
      .O_txdata              (m_data),
      .O_frame_start         (m_fs),
      .O_frame_cnt           (m_cnt),
      .O_inject_done         (m_idone)
   );

   serdes_test_data_gen #(.C_CHANNEL_FOR_CPRI_TDM(1'b1)) u_tdm (
      .I_txoutclk            (clk),
      .I_txoutrst            (rst),
      .I_gen_en              (gen_en),
      .I_serdes_rate_sel     (rate_sel),
      .I_8b10b_or_64b66b_sel (coding_sel),
      .I_err_inject          (err_inject),
      .O_txctrl              (t_ctrl),
      .O_txdata              (t_data),
      .O_frame_start         (t_fs),
      .O_frame_cnt           (t_cnt),
      .O_inject_done         (t_idone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Steps until the CPRI instance pulses frame_start; also returns the word before it
   task automatic wait_start(input int limit, output int cnt, output logic [63:0] last);
      cnt  = 0;
      last = m_data;
      do begin
         last = m_data;
         @(negedge clk);
         cnt++;
      end while (!m_fs && cnt < limit);
      if (!m_fs) chk("frame_start_timeout", 64'(cnt), 64'(limit + 1));
   endtask

   task automatic step(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      gen_en     = 1'b0;
      rate_sel   = 4'd0;
      coding_sel = 1'b0;
      err_inject = 1'b0;
      step(2);
      chk("rst_data",  m_data, 64'h0);
      chk("rst_ctrl",  64'(m_ctrl), 64'h0);
      chk("rst_cnt",   64'(m_cnt), 64'h0);
      chk("rst_fs",    64'(m_fs), 64'h0);
      chk("rst_tdata", t_data, 64'h0);

      // CPRI 8b10b rate 0
      rst    = 1'b0;
      gen_en = 1'b1;
      step(1);
      chk("start_lat_data", m_data, 64'h0);
      step(1);
      chk("h1_ctrl", 64'(m_ctrl), 64'h01);
      chk("h1_data", m_data, 64'h50505050505050BC);
      chk("h1_fs",   64'(m_fs), 64'h1);
      chk("h1_cnt",  64'(m_cnt), 64'h1);
      step(1);
      chk("h2_ctrl", 64'(m_ctrl), 64'h00);
      chk("h2_data", m_data, 64'h5050505050505050);
      chk("h2_fs",   64'(m_fs), 64'h0);
      step(1);
      chk("w2_data", m_data, 64'h0002000000020002);
      wait_start(1100, n, prev);
      chk("period_r0", 64'(n), 64'd1022);
      chk("last_r0",   prev, 64'h03FF000003FF03FF);
      chk("cnt_2",     64'(m_cnt), 64'h2);

      // Drop enable at k = 10: drain to the terminal word
      step(9);
      gen_en = 1'b0;
      step(1);
      chk("drain_w10", m_data, 64'h000A0000000A000A);
      step(1013);
      chk("drain_last", m_data, 64'h03FF000003FF03FF);
      step(1);
      chk("drain_idle_data", m_data, 64'h0);
      chk("drain_idle_ctrl", 64'(m_ctrl), 64'h0);
      step(5);
      chk("drain_idle_data2", m_data, 64'h0);
      chk("drain_cnt", 64'(m_cnt), 64'h2);

      // Rate change mid-frame applies to the next frame only
      gen_en = 1'b1;
      step(2);
      chk("rc_h1_fs",  64'(m_fs), 64'h1);
      chk("rc_h1_cnt", 64'(m_cnt), 64'h3);
      step(99);
      rate_sel = 4'd1;
      wait_start(1100, n, prev);
      chk("rc_old_period", 64'(n), 64'd925);
      wait_start(2100, n, prev);
      chk("rc_new_period", 64'(n), 64'd2048);
      chk("rc_last", prev, 64'h07FF000007FF07FF);
      chk("rc_cnt", 64'(m_cnt), 64'h5);

      // Error injection held 3 cycles starting in the header
      err_inject = 1'b1;
      step(1);
      chk("inj_h2_data",  m_data, 64'h5050505050505050);
      chk("inj_h2_done",  64'(m_idone), 64'h0);
      step(1);
      chk("inj_w2_data",  m_data, 64'h0002000000020003);
      chk("inj_w2_ctrl",  64'(m_ctrl), 64'h00);
      chk("inj_w2_done",  64'(m_idone), 64'h1);
      step(1);
      err_inject = 1'b0;
      chk("inj_w3_data",  m_data, 64'h0003000000030003);
      chk("inj_w3_done",  64'(m_idone), 64'h0);
      step(1);
      chk("inj_w4_data",  m_data, 64'h0004000000040004);

      // 64b66b rate 9, applied at the next frame
      coding_sel = 1'b1;
      rate_sel   = 4'd9;
      wait_start(2100, n, prev);
      chk("r9_switch_period", 64'(n), 64'd2044);
      chk("r9_h1_ctrl", 64'(m_ctrl), 64'h80);
      chk("r9_h1_data", m_data, 64'hFD50505050505050);
      step(1);
      chk("r9_h2_ctrl", 64'(m_ctrl), 64'h01);
      chk("r9_h2_data", m_data, 64'h50505050505050FB);
      wait_start(25000, n, prev);
      chk("r9_period", 64'(n), 64'd24575);
      chk("r9_last",   prev, 64'h5FFF00005FFF5FFF);
      chk("r9_cnt",    64'(m_cnt), 64'h7);

      // TDM rate 0: four-word frames, then reset mid-frame
      rst    = 1'b1;
      gen_en = 1'b0;
      step(1);
      chk("rst2_tdata", t_data, 64'h0);
      chk("rst2_tcnt",  64'(t_cnt), 64'h0);
      rst        = 1'b0;
      coding_sel = 1'b0;
      rate_sel   = 4'd0;
      gen_en     = 1'b1;
      step(2);
      chk("tdm_h1_data", t_data, 64'h50505050505050BC);
      chk("tdm_h1_ctrl", 64'(t_ctrl), 64'h01);
      chk("tdm_h1_fs",   64'(t_fs), 64'h1);
      step(1);
      chk("tdm_h2_data", t_data, 64'h5050505050505050);
      step(1);
      chk("tdm_w2_data", t_data, 64'h0002000000020002);
      step(1);
      chk("tdm_w3_data", t_data, 64'h0003000000030003);
      step(1);
      chk("tdm_h1b_data", t_data, 64'h50505050505050BC);
      chk("tdm_h1b_fs",   64'(t_fs), 64'h1);
      chk("tdm_h1b_cnt",  64'(t_cnt), 64'h2);
      step(2);
      chk("tdm_w2b_data", t_data, 64'h0002000000020002);
      rst = 1'b1;
      step(1);
      chk("tdm_rst_data", t_data, 64'h0);
      chk("tdm_rst_ctrl", 64'(t_ctrl), 64'h0);
      chk("tdm_rst_cnt",  64'(t_cnt), 64'h0);
      chk("tdm_rst_fs",   64'(t_fs), 64'h0);
      chk("cpri_rst_data", m_data, 64'h0);
      rst    = 1'b0;
      gen_en = 1'b0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
